lp_tree_serializer_sched: RTL and testbench

Frame scheduler and round-robin arbiter sitting in front of the low-power tree serializer. Accepts 16-bit words from NUM_REQ requesters over valid/ready, applies the serializer's fixed bit-reversed input permutation, and holds the permuted word on the serializer's parallel input for a fixed serialization window followed by a zero-filled gap. It is the only driver of the serializer's PAR_IN bus.

---
 rtl/lp_tree_serializer_sched.sv | 155 +++++++++++++++
 tb/tb_lp_tree_serializer_sched.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lp_tree_serializer_sched.sv
`default_nettype none
// ============================================================================
//  Module   : lp_tree_serializer_sched
//  Purpose  : Frame scheduler + round-robin arbiter in front of the low-power
//             tree serializer. Grants one of NUM_REQ requesters, applies the
//             serializer's bit-reversed input permutation and holds the word
//             on par_in for HOLD_CYCLES cycles, followed by GAP_CYCLES cycles
//             of zeros. Sole driver of the serializer parallel input.
//  Ports    : clk, rst_n (async, active-low), enable (allow new grants)
//             req_valid/req_data/req_ready : per-requester valid/ready words
//             par_in     : registered permuted word (0 in IDLE/GAP)
//             busy       : registered, 1 in HOLD or GAP
//             grant_id   : registered index of the in-flight requester
//             frame_done : one-cycle pulse on first IDLE cycle after a frame
//  Revision : 1.0  initial release
// ============================================================================
module lp_tree_serializer_sched #(
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = 21,
    parameter int GAP_CYCLES  = 7,
    localparam int IDW        = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [16*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic [15:0]             par_in,
    output logic                    busy,
    output logic [IDW-1:0]          grant_id,
    output logic                    frame_done
);

    localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam bit HAS_GAP = (GAP_CYCLES > 0);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(HAS_GAP ? GAP_CYCLES - 1 : 0);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    logic [1:0]     state;
    logic [IDW-1:0] ptr;
    logic [CW-1:0]  cnt;
    logic [IDW-1:0] winner;
    logic           any_valid;
    logic           fire;
    logic [15:0]    sel_word;

    // Serializer input ordering: par[i] = w[15 - bitrev4(i)].
    function automatic logic [15:0] perm16(input logic [15:0] w);
        logic [3:0] i4;
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 16; i++) begin
            i4   = 4'(i);
            p[i] = w[4'd15 - {i4[0], i4[1], i4[2], i4[3]}];
        end
        return p;
    endfunction

    // Round-robin pick: scan offsets from NUM_REQ down to 1 so that the
    // last hit written is the first valid requester after ptr (with wrap).
    always_comb begin
        int idx;
        winner    = '0;
        any_valid = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (req_valid[idx]) begin
                winner    = IDW'(idx);
                any_valid = 1'b1;
            end
        end
    end

    always_comb begin
        sel_word = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (winner == IDW'(r)) begin
                sel_word = req_data[16*r +: 16];
            end
        end
    end

    assign fire = (state == ST_IDLE) && enable && any_valid;

    // Ready is gated with rst_n so it is low for the whole reset assertion.
    always_comb begin
        req_ready = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            req_ready[r] = fire && rst_n && (winner == IDW'(r));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            par_in     <= '0;
            busy       <= 1'b0;
            grant_id   <= '0;
            frame_done <= 1'b0;
            ptr        <= IDW'(NUM_REQ - 1);
            cnt        <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (fire) begin
                        state    <= ST_HOLD;
                        par_in   <= perm16(sel_word);
                        busy     <= 1'b1;
                        grant_id <= winner;
                        ptr      <= winner;
                        cnt      <= HOLD_LOAD;
                    end
                end
                ST_HOLD: begin
                    if (cnt == '0) begin
                        par_in <= '0;
                        if (HAS_GAP) begin
                            state <= ST_GAP;
                            cnt   <= GAP_LOAD;
                        end else begin
                            state      <= ST_IDLE;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (cnt == '0) begin
                        state      <= ST_IDLE;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    par_in <= '0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lp_tree_serializer_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lp_tree_serializer_sched
//  Purpose  : Self-checking bench for lp_tree_serializer_sched. A default
//             build (4 req, 21 hold, 7 gap) is checked every cycle against a
//             frame-timing reference model; a second build (2 req, 1 hold,
//             0 gap) checks back-to-back operation.
//  Revision : 1.0  initial release
// ============================================================================
module tb_lp_tree_serializer_sched;

    localparam int N = 4;
    localparam int H = 21;
    localparam int G = 7;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [N-1:0] valid;
    logic [15:0] dword [N];
    logic [16*N-1:0] req_data;
    logic [N-1:0] req_ready;
    logic [15:0] par_in;
    logic        busy;
    logic [1:0]  grant_id;
    logic        frame_done;

    logic        en2;
    logic [1:0]  v2;
    logic [31:0] d2;
    logic [1:0]  rdy2;
    logic [15:0] par2;
    logic        busy2;
    logic [0:0]  gid2;
    logic        fd2;

    assign req_data = {dword[3], dword[2], dword[1], dword[0]};

    always #5 clk = ~clk;

    lp_tree_serializer_sched #(.NUM_REQ(N), .HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .req_valid(valid),
        .req_data(req_data), .req_ready(req_ready), .par_in(par_in),
        .busy(busy), .grant_id(grant_id), .frame_done(frame_done)
    );

    lp_tree_serializer_sched #(.NUM_REQ(2), .HOLD_CYCLES(1), .GAP_CYCLES(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .enable(en2), .req_valid(v2),
        .req_data(d2), .req_ready(rdy2), .par_in(par2),
        .busy(busy2), .grant_id(gid2), .frame_done(fd2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: frames described by their handshake edge.
    int          cyc;
    bit          have_frame;
    int          start;
    logic [15:0] m_word;
    int          m_ptr;
    int          m_gid;
    int          g_id [$];
    int          g_cyc [$];

    logic [15:0] last_par;
    logic        last_busy;
    logic        last_fd;
    logic [N-1:0] last_hs;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_perm(input logic [15:0] w);
        logic [15:0] p;
        int r;
        for (int i = 0; i < 16; i++) begin
            r = ((i & 1) << 3) | ((i & 2) << 1) | ((i & 4) >> 1) | ((i & 8) >> 3);
            p[i] = w[15 - r];
        end
        return p;
    endfunction

    function automatic int model_winner(input int ptr, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        have_frame = 0;
        m_ptr      = N - 1;
        m_gid      = 0;
        cyc        = 0;
        g_id.delete();
        g_cyc.delete();
    endtask

    // One clock: compare all outputs at the falling edge, then advance the
    // model at the rising edge. Returns 1 time unit after the rising edge.
    task automatic cycle();
        logic [N-1:0] er;
        logic [15:0]  ep;
        bit eb, efd, idle;
        int el, w;
        @(negedge clk);
        ep = 16'h0; eb = 0; efd = 0; idle = 1;
        if (have_frame) begin
            el = cyc - start;
            if (el < H) begin
                ep = model_perm(m_word); eb = 1; idle = 0;
            end else if (el < H + G) begin
                eb = 1; idle = 0;
            end else begin
                efd = (el == H + G);
            end
        end
        er = '0;
        w  = model_winner(m_ptr, valid);
        if (idle && enable && w >= 0) er[w] = 1'b1;
        check("par_in", 32'(par_in), 32'(ep));
        check("busy", 32'(busy), 32'(eb));
        check("frame_done", 32'(frame_done), 32'(efd));
        check("req_ready", 32'(req_ready), 32'(er));
        check("grant_id", 32'(grant_id), 32'(m_gid));
        last_par  = par_in;
        last_busy = busy;
        last_fd   = frame_done;
        last_hs   = valid & req_ready;
        @(posedge clk);
        cyc++;
        for (int r = 0; r < N; r++) begin
            if (last_hs[r]) begin
                g_id.push_back(r);
                g_cyc.push_back(cyc);
            end
        end
        if (er != '0) begin
            have_frame = 1;
            start      = cyc;
            m_word     = dword[w];
            m_ptr      = w;
            m_gid      = w;
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        valid  = '0;
        enable = 1'b1;
        en2    = 1'b0;
        v2     = '0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic wait_grant(input string tag);
        int guard = 0;
        last_hs = '0;
        while (last_hs == '0 && guard < 100) begin
            cycle();
            guard++;
        end
        check({tag, "_grant_timeout"}, 32'(guard < 100), 32'd1);
    endtask

    task automatic single(input int r, input logic [15:0] w, input logic [15:0] exp_par, input string tag);
        int hold_n = 0;
        int gap_n  = 0;
        bit done   = 0;
        bit fd_seen = 0;
        valid[r] = 1'b1;
        dword[r] = w;
        wait_grant(tag);
        valid[r] = 1'b0;
        for (int i = 0; i < 80 && !done; i++) begin
            cycle();
            if (last_busy && last_par === exp_par && gap_n == 0) hold_n++;
            else if (last_busy && last_par === 16'h0) gap_n++;
            else begin
                fd_seen = last_fd;
                done    = 1;
            end
        end
        check({tag, "_hold_len"}, 32'(hold_n), 32'(H));
        check({tag, "_gap_len"}, 32'(gap_n), 32'(G));
        check({tag, "_frame_done"}, 32'(fd_seen), 32'd1);
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b1;
        valid  = 4'b1111;
        for (int r = 0; r < N; r++) dword[r] = 16'($urandom);
        en2 = 1'b1; v2 = 2'b11; d2 = 32'h1234_5678;

        // Reset state while all requesters are valid.
        #3;
        check("rst_par_in", 32'(par_in), 32'h0);
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_gid", 32'(grant_id), 32'h0);
        check("rst_fd", 32'(frame_done), 32'h0);
        check("rst_ready2", 32'(rdy2), 32'h0);
        @(posedge clk); @(negedge clk);
        check("rst_ready_edge", 32'(req_ready), 32'h0);
        check("rst_par_edge", 32'(par_in), 32'h0);
        do_reset();

        // Single words and the permutation examples.
        single(0, 16'hC5AF, 16'hCDAB, "w_c5af");
        single(1, 16'h0001, 16'h8000, "w_0001");
        single(2, 16'hFFFF, 16'hFFFF, "w_ffff");

        // Asynchronous reset in the middle of HOLD.
        valid[3] = 1'b1; dword[3] = 16'hA5A5;
        wait_grant("midrst");
        valid[3] = 1'b0;
        repeat (5) cycle();
        #2 rst_n = 1'b0;
        #1;
        check("midrst_par_in", 32'(par_in), 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_ready", 32'(req_ready), 32'h0);
        do_reset();
        repeat (3) cycle();

        // Round-robin with all requesters permanently valid.
        do_reset();
        valid = 4'b1111;
        for (int i = 0; i < 300 && g_id.size() < 8; i++) begin
            cycle();
            for (int r = 0; r < N; r++) if (last_hs[r]) dword[r] = 16'($urandom);
        end
        check("rr_count", 32'(g_id.size()), 32'd8);
        for (int i = 0; i < 8 && i < g_id.size(); i++) begin
            check("rr_order", 32'(g_id[i]), 32'(i % N));
            if (i > 0) check("rr_period", 32'(g_cyc[i] - g_cyc[i-1]), 32'(1 + H + G));
        end

        // Skip and wrap: get ptr to 1, then only 3 and 1 valid.
        do_reset();
        valid = 4'b0010;
        wait_grant("skip_first");
        valid = 4'b1010;
        for (int i = 0; i < 200 && g_id.size() < 4; i++) cycle();
        check("skip_count", 32'(g_id.size()), 32'd4);
        if (g_id.size() >= 4) begin
            check("skip_g0", 32'(g_id[0]), 32'd1);
            check("skip_g1", 32'(g_id[1]), 32'd3);
            check("skip_g2", 32'(g_id[2]), 32'd1);
            check("skip_g3", 32'(g_id[3]), 32'd3);
        end

        // ENABLE dropped mid-HOLD: frame completes, nothing new until raised.
        do_reset();
        valid = 4'b0100;
        wait_grant("en_first");
        valid = 4'b0001;
        repeat (3) cycle();
        enable = 1'b0;
        repeat (40) cycle();
        check("en_no_grant", 32'(g_id.size()), 32'd1);
        enable = 1'b1;
        cycle();
        check("en_regrant_count", 32'(g_id.size()), 32'd2);
        if (g_id.size() >= 2) begin
            check("en_regrant_id", 32'(g_id[1]), 32'd0);
            check("en_regrant_cyc", 32'(g_cyc[1]), 32'(cyc));
        end

        // Randomized traffic, including spontaneous valid drops.
        for (int i = 0; i < 800; i++) begin
            cycle();
            enable = ($urandom_range(0, 9) != 0);
            for (int r = 0; r < N; r++) begin
                if (last_hs[r] || !valid[r]) begin
                    valid[r] = ($urandom_range(0, 3) == 0);
                    dword[r] = 16'($urandom);
                end else if ($urandom_range(0, 49) == 0) begin
                    valid[r] = 1'b0;
                end
            end
        end

        // Minimal build: one-cycle hold, no gap, back-to-back requests.
        do_reset();
        en2 = 1'b1; v2 = 2'b01; d2 = 32'h0000_1234;
        #1;
        check("b2b_ready_idle0", 32'(rdy2), 32'h1);
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("b2b_par_word", 32'(par2), 32'(model_perm(16'h1234)));
            check("b2b_busy_word", 32'(busy2), 32'h1);
            check("b2b_ready_word", 32'(rdy2), 32'h0);
            cycle();
            check("b2b_par_idle", 32'(par2), 32'h0);
            check("b2b_fd_idle", 32'(fd2), 32'h1);
            check("b2b_busy_idle", 32'(busy2), 32'h0);
            check("b2b_ready_idle", 32'(rdy2), 32'h1);
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
